// File: rtl/spi_pkg.sv
// Shared definitions for the SPI controller register interface: control-word
// bit positions, register selector values and the sequencer state encoding.
package spi_pkg;

    localparam int SEND_BIT = 0;
    localparam int ALL1_BIT = 1;
    localparam int ALL0_BIT = 2;
    localparam int NTX_LSB  = 4;
    localparam int NRX_LSB  = 16;

    localparam logic REG_CTRL = 1'b0;
    localparam logic REG_DATA = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR_DATA = 3'd1,
        ST_WR_CTRL = 3'd2,
        ST_POLL    = 3'd3,
        ST_RD_DATA = 3'd4,
        ST_FIN     = 3'd5,
        ST_ERR     = 3'd6
    } estado_t;

    // Control word that launches a transfer of n_tx bytes out and n_rx bytes back.
    function automatic logic [31:0] ctrl_word(input int n_tx, input int n_rx);
        logic [31:0] w;
        w                 = '0;
        w[SEND_BIT]       = 1'b1;
        w[ALL1_BIT]       = 1'b0;
        w[ALL0_BIT]       = 1'b0;
        w[NTX_LSB +: 9]   = 9'(n_tx - 1);
        w[NRX_LSB +: 10]  = 10'(n_rx - 1);
        return w;
    endfunction

endpackage

// File: rtl/sincronizador_flanco.sv
// Two-flop synchronizer for an asynchronous pushbutton followed by a
// rising-edge detector; flanco_o is a single-cycle pulse per press.
module sincronizador_flanco (
    input  logic clk_i,
    input  logic reset_i,
    input  logic boton_i,
    output logic flanco_o
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;
    logic prev_q, prev_d;

    always_comb begin
        meta_d = boton_i;
        sync_d = meta_q;
        prev_d = sync_q;
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign flanco_o = sync_q & ~prev_q;

endmodule

// File: rtl/secuenciador_spi.sv
// Start-button driven sequencer for the SPI controller: writes the payload and
// control word, polls for completion, then streams the received bytes out.
module secuenciador_spi
    import spi_pkg::*;
#(
    parameter int N_TX    = 1,
    parameter int N_RX    = 1,
    parameter int TIMEOUT = 2_000_000
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        inicio_i,
    input  logic [7:0]  dato_tx_i,
    input  logic [31:0] salida_i,
    output logic        wr_o,
    output logic        reg_sel_o,
    output logic [31:0] entrada_o,
    output logic [31:0] addr_o,
    output logic        ocupado_o,
    output logic        rx_valid_o,
    output logic [7:0]  dato_rx_o,
    output logic        listo_o,
    output logic        error_o
);

    localparam int               CNT_W     = ($clog2(TIMEOUT + 1) > 2) ? $clog2(TIMEOUT + 1) : 2;
    localparam logic [CNT_W-1:0] CNT_FIN   = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_LAT   = CNT_W'(2);
    localparam logic [4:0]       TX_LAST   = 5'(N_TX - 1);
    localparam logic [4:0]       RX_END    = 5'(N_RX);
    localparam logic [31:0]      CTRL_WORD = ctrl_word(N_TX, N_RX);

    estado_t          estado_q, estado_d;
    logic [4:0]       idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pend_q, pend_d;
    logic [7:0]       dato_q, dato_d;
    logic             error_q, error_d;
    logic             flanco;
    logic             salida_unused;

    assign salida_unused = ^salida_i[31:8];

    sincronizador_flanco u_sinc (
        .clk_i    (clk_i),
        .reset_i  (reset_i),
        .boton_i  (inicio_i),
        .flanco_o (flanco)
    );

    always_comb begin
        estado_d = estado_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        error_d  = error_q;
        pend_d   = 1'b0;
        dato_d   = pend_q ? salida_i[7:0] : dato_q;
        case (estado_q)
            ST_IDLE: begin
                // Edges arriving outside IDLE are simply lost, never queued.
                if (flanco) begin
                    estado_d = ST_WR_DATA;
                    idx_d    = '0;
                    error_d  = 1'b0;
                end
            end
            ST_WR_DATA: begin
                if (idx_q == TX_LAST) begin
                    estado_d = ST_WR_CTRL;
                    idx_d    = '0;
                end else begin
                    idx_d = idx_q + 5'd1;
                end
            end
            ST_WR_CTRL: begin
                estado_d = ST_POLL;
                cnt_d    = '0;
            end
            ST_POLL: begin
                // Completion is checked before the timeout so a late clear still succeeds.
                if (cnt_q >= CNT_LAT && !salida_i[SEND_BIT]) begin
                    estado_d = ST_RD_DATA;
                    idx_d    = '0;
                end else if (cnt_q == CNT_FIN) begin
                    estado_d = ST_ERR;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RD_DATA: begin
                // idx == N_RX is the drain cycle in which the last byte is captured.
                pend_d = (idx_q != RX_END);
                if (idx_q == RX_END) begin
                    estado_d = ST_FIN;
                end else begin
                    idx_d = idx_q + 5'd1;
                end
            end
            ST_FIN: begin
                estado_d = ST_IDLE;
            end
            ST_ERR: begin
                error_d  = 1'b1;
                estado_d = ST_IDLE;
            end
            default: begin
                estado_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            estado_q <= ST_IDLE;
            idx_q    <= '0;
            cnt_q    <= '0;
            pend_q   <= 1'b0;
            dato_q   <= '0;
            error_q  <= 1'b0;
        end else begin
            estado_q <= estado_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            pend_q   <= pend_d;
            dato_q   <= dato_d;
            error_q  <= error_d;
        end
    end

    always_comb begin
        wr_o      = 1'b0;
        reg_sel_o = REG_CTRL;
        entrada_o = '0;
        addr_o    = '0;
        case (estado_q)
            ST_WR_DATA: begin
                wr_o      = 1'b1;
                reg_sel_o = REG_DATA;
                addr_o    = {28'b0, idx_q[3:0]};
                entrada_o = {24'b0, dato_tx_i + 8'(idx_q)};
            end
            ST_WR_CTRL: begin
                wr_o      = 1'b1;
                entrada_o = CTRL_WORD;
            end
            ST_RD_DATA: begin
                reg_sel_o = REG_DATA;
                if (idx_q != RX_END) begin
                    addr_o = {28'b0, idx_q[3:0]};
                end
            end
            default: begin
                wr_o = 1'b0;
            end
        endcase
    end

    // The byte is shown straight from the read port during its pulse, then held.
    assign rx_valid_o = pend_q;
    assign dato_rx_o  = pend_q ? salida_i[7:0] : dato_q;
    assign ocupado_o  = (estado_q != ST_IDLE);
    assign listo_o    = (estado_q == ST_FIN);
    assign error_o    = error_q;

endmodule

// File: tb/tb_secuenciador_spi.sv
// Directed bench for secuenciador_spi with a small register-level model of the
// SPI controller (control register, receive memory, registered read port).
module tb_secuenciador_spi;

    localparam int          N_TX     = 3;
    localparam int          N_RX     = 2;
    localparam int          TIMEOUT  = 100;
    localparam logic [31:0] CTRL_EXP = 32'h0001_0021;  // n_rx_end=1, n_tx_end=2, send=1

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        inicio = 1'b0;
    logic [7:0]  dato_tx = 8'h00;
    logic [31:0] salida = 32'h0;
    logic        wr_o, reg_sel_o, ocupado_o, rx_valid_o, listo_o, error_o;
    logic [31:0] entrada_o, addr_o;
    logic [7:0]  dato_rx_o;

    secuenciador_spi #(.N_TX(N_TX), .N_RX(N_RX), .TIMEOUT(TIMEOUT)) u_dut (
        .clk_i      (clk),
        .reset_i    (rst),
        .inicio_i   (inicio),
        .dato_tx_i  (dato_tx),
        .salida_i   (salida),
        .wr_o       (wr_o),
        .reg_sel_o  (reg_sel_o),
        .entrada_o  (entrada_o),
        .addr_o     (addr_o),
        .ocupado_o  (ocupado_o),
        .rx_valid_o (rx_valid_o),
        .dato_rx_o  (dato_rx_o),
        .listo_o    (listo_o),
        .error_o    (error_o)
    );

    // ---------------- clock / cycle counter ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- controller model ----------------
    logic [31:0] ctrl_m = 32'h0;
    int          bcnt = 0;
    int          clear_after = 50;  // 0 = send never clears
    logic [7:0]  rx_mem [16];

    always @(posedge clk) begin
        if (wr_o && !reg_sel_o) begin
            ctrl_m <= entrada_o;
            bcnt   <= 0;
        end else if (ctrl_m[0] && clear_after != 0) begin
            if (bcnt == clear_after - 1) ctrl_m[0] <= 1'b0;
            else bcnt <= bcnt + 1;
        end
        salida <= reg_sel_o ? {24'b0, rx_mem[addr_o[3:0]]} : ctrl_m;
    end

    // ---------------- monitor ----------------
    logic [31:0] wr_data_q[$];
    logic [31:0] wr_addr_q[$];
    logic        wr_sel_q[$];
    int          wr_cyc_q[$];
    logic [7:0]  rx_data_q[$];
    int          rx_cyc_q[$];
    int          listo_n = 0;
    int          listo_cyc = 0;
    int          ctrl_cyc = 0;
    int          err_cyc = 0;
    logic        err_seen = 1'b0;

    always @(negedge clk) begin
        if (!rst) begin
            if (wr_o) begin
                wr_data_q.push_back(entrada_o);
                wr_addr_q.push_back(addr_o);
                wr_sel_q.push_back(reg_sel_o);
                wr_cyc_q.push_back(cyc);
                if (!reg_sel_o) ctrl_cyc = cyc;
            end
            if (rx_valid_o) begin
                rx_data_q.push_back(dato_rx_o);
                rx_cyc_q.push_back(cyc);
            end
            if (listo_o) begin
                listo_n++;
                listo_cyc = cyc;
            end
            if (error_o && !err_seen) begin
                err_seen = 1'b1;
                err_cyc  = cyc;
            end
        end
    end

    // ---------------- scoreboard / checking ----------------
    logic [31:0] exp_q[$];
    int          n_cmp = 0;
    int          n_mis = 0;
    int          press_cyc = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic press();
        inicio    = 1'b1;
        press_cyc = cyc;
    endtask

    task automatic clear_logs();
        wr_data_q.delete();
        wr_addr_q.delete();
        wr_sel_q.delete();
        wr_cyc_q.delete();
        rx_data_q.delete();
        rx_cyc_q.delete();
        exp_q.delete();
        listo_n  = 0;
        err_seen = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int   n;
        logic done;
        n    = 0;
        done = (listo_n > 0) || error_o;
        while (!done && n < budget) begin
            tick(1);
            n++;
            done = (listo_n > 0) || error_o;
        end
        chk(tag, 32'(done), 32'd1);
    endtask

    task automatic check_writes(input string tag, input logic [7:0] base);
        logic [7:0] b;
        for (int i = 0; i < N_TX; i++) begin
            b = base + 8'(i);
            exp_q.push_back({24'b0, b});
        end
        exp_q.push_back(CTRL_EXP);
        chk({tag, "_nwr"}, 32'(wr_data_q.size()), 32'(N_TX + 1));
        chk({tag, "_wr_lat"}, 32'(wr_cyc_q.size() > 0 ? wr_cyc_q[0] - press_cyc : -1), 32'd3);
        for (int i = 0; i < N_TX + 1 && i < wr_data_q.size(); i++) begin
            chk($sformatf("%s_wdata%0d", tag, i), wr_data_q[i], exp_q[i]);
            chk($sformatf("%s_wsel%0d", tag, i), 32'(wr_sel_q[i]), (i < N_TX) ? 32'd1 : 32'd0);
            chk($sformatf("%s_waddr%0d", tag, i), wr_addr_q[i], (i < N_TX) ? 32'(i) : 32'd0);
            chk($sformatf("%s_wcyc%0d", tag, i), 32'(wr_cyc_q[i] - wr_cyc_q[0]), 32'(i));
        end
    endtask

    task automatic check_rx(input string tag, input int k);
        chk({tag, "_nrx"}, 32'(rx_data_q.size()), 32'd2);
        if (rx_data_q.size() == 2) begin
            chk({tag, "_rx0"}, 32'(rx_data_q[0]), 32'h5A);
            chk({tag, "_rx1"}, 32'(rx_data_q[1]), 32'hC3);
            chk({tag, "_rx0_cyc"}, 32'(rx_cyc_q[0] - ctrl_cyc), 32'(k + 4));
            chk({tag, "_rx1_cyc"}, 32'(rx_cyc_q[1] - rx_cyc_q[0]), 32'd1);
            chk({tag, "_listo_cyc"}, 32'(listo_cyc - rx_cyc_q[1]), 32'd1);
        end
        chk({tag, "_nlisto"}, 32'(listo_n), 32'd1);
        chk({tag, "_error"}, 32'(error_o), 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_wr"}, 32'(wr_o), 32'd0);
        chk({tag, "_reg_sel"}, 32'(reg_sel_o), 32'd0);
        chk({tag, "_entrada"}, entrada_o, 32'd0);
        chk({tag, "_addr"}, addr_o, 32'd0);
        chk({tag, "_ocupado"}, 32'(ocupado_o), 32'd0);
        chk({tag, "_rx_valid"}, 32'(rx_valid_o), 32'd0);
        chk({tag, "_dato_rx"}, 32'(dato_rx_o), 32'd0);
        chk({tag, "_listo"}, 32'(listo_o), 32'd0);
        chk({tag, "_error"}, 32'(error_o), 32'd0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        for (int i = 0; i < 16; i++) rx_mem[i] = 8'h00;
        rx_mem[0] = 8'h5A;
        rx_mem[1] = 8'hC3;

        // Reset state
        tick(2);
        check_all_zero("rst");
        rst = 1'b0;
        tick(5);

        // Main sequence, button held high across completion
        clear_logs();
        clear_after = 50;
        dato_tx     = 8'hFE;
        press();
        wait_done("main_done", 300);
        tick(1);
        chk("main_dato_hold", 32'(dato_rx_o), 32'hC3);
        tick(20);
        check_writes("main", 8'hFE);
        check_rx("main", 50);
        chk("main_ocupado", 32'(ocupado_o), 32'd0);
        inicio = 1'b0;
        tick(5);

        // Second edge during POLL is discarded
        clear_logs();
        dato_tx = 8'h10;
        press();
        tick(5);
        inicio = 1'b0;
        tick(15);
        inicio = 1'b1;
        tick(5);
        inicio = 1'b0;
        wait_done("poll_done", 300);
        tick(30);
        check_writes("poll", 8'h10);
        check_rx("poll", 50);

        // Edge whose pulse lands on the FIN cycle is not accepted
        clear_logs();
        dato_tx = 8'h33;
        press();
        tick(5);
        inicio = 1'b0;
        tick(55);
        inicio = 1'b1;
        tick(30);
        chk("fin_listo_cyc", 32'(listo_cyc - press_cyc), 32'd62);
        chk("fin_nlisto", 32'(listo_n), 32'd1);
        chk("fin_nwr", 32'(wr_data_q.size()), 32'(N_TX + 1));
        chk("fin_ocupado", 32'(ocupado_o), 32'd0);
        inicio = 1'b0;
        tick(5);
        clear_logs();
        press();
        tick(3);
        chk("fin_restart_wr", 32'(wr_o), 32'd1);
        wait_done("fin_restart_done", 300);
        tick(2);
        check_writes("fin_restart", 8'h33);
        inicio = 1'b0;
        tick(5);

        // Timeout: send never clears
        clear_logs();
        clear_after = 0;
        press();
        tick(5);
        inicio = 1'b0;
        wait_done("to_done", 400);
        tick(1);
        chk("to_err_cyc", 32'(err_cyc - ctrl_cyc), 32'd102);
        chk("to_nrx", 32'(rx_data_q.size()), 32'd0);
        chk("to_nlisto", 32'(listo_n), 32'd0);
        chk("to_ocupado", 32'(ocupado_o), 32'd0);
        tick(20);
        chk("to_sticky", 32'(error_o), 32'd1);
        clear_logs();
        clear_after = 50;
        press();
        tick(3);
        chk("to_clear_err", 32'(error_o), 32'd0);
        chk("to_clear_wr", 32'(wr_o), 32'd1);
        tick(2);
        inicio = 1'b0;
        wait_done("to_retry_done", 300);
        tick(2);
        check_rx("to_retry", 50);
        tick(5);

        // send seen clear on the last counted POLL cycle: success wins
        clear_logs();
        clear_after = 98;
        press();
        tick(5);
        inicio = 1'b0;
        wait_done("edge_done", 400);
        tick(3);
        check_rx("edge", 98);
        tick(5);

        // Asynchronous reset mid write phase
        clear_logs();
        clear_after = 50;
        press();
        tick(5);
        rst = 1'b1;
        #1;
        check_all_zero("midrst");
        inicio = 1'b0;
        tick(3);
        rst = 1'b0;
        clear_logs();
        tick(40);
        chk("midrst_nwr", 32'(wr_data_q.size()), 32'd0);
        chk("midrst_ocupado", 32'(ocupado_o), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
